// File: rtl/block_mul_2x2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : block_mul_2x2
//  Description : Sequential 2x2 signed block multiply-accumulate unit.
//                One shared multiplier is stepped over eight products, and
//                the 2x2 result tile is then presented for write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_mul_2x2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [DATA_WIDTH-1:0] a_ul,
  input  logic [DATA_WIDTH-1:0] a_ur,
  input  logic [DATA_WIDTH-1:0] a_dl,
  input  logic [DATA_WIDTH-1:0] a_dr,
  input  logic [DATA_WIDTH-1:0] b_ul,
  input  logic [DATA_WIDTH-1:0] b_ur,
  input  logic [DATA_WIDTH-1:0] b_dl,
  input  logic [DATA_WIDTH-1:0] b_dr,
  output logic                  ready,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] c_ul,
  output logic [DATA_WIDTH-1:0] c_ur,
  output logic [DATA_WIDTH-1:0] c_dl,
  output logic [DATA_WIDTH-1:0] c_dr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2:0]              step;
  logic                    accept;

  // Operand copies taken at the accepting edge
  logic [DATA_WIDTH-1:0]   ra_ul, ra_ur, ra_dl, ra_dr;
  logic [DATA_WIDTH-1:0]   rb_ul, rb_ur, rb_dl, rb_dr;
  // Running partial sums of the four result elements
  logic [DATA_WIDTH-1:0]   p_ul, p_ur, p_dl, p_dr;

  logic [DATA_WIDTH-1:0]   mul_a;
  logic [DATA_WIDTH-1:0]   mul_b;
  logic [DATA_WIDTH-1:0]   prod;
  logic [DATA_WIDTH-1:0]   sel_p;
  logic [DATA_WIDTH-1:0]   sum;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = MUL;
      end
      MUL: begin
        if (step == 3'd7) state_next = DONE;
      end
      DONE: begin
        ready        = 1'b1;
        result_valid = 1'b1;
        state_next   = start ? MUL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = start && ready;

  // Operand selection: step[2] picks the A row, step[1] the B column,
  // step[0] walks the inner dimension.
  always_comb begin
    mul_a = step[0] ? (step[2] ? ra_dr : ra_ur) : (step[2] ? ra_dl : ra_ul);
    mul_b = step[1] ? (step[0] ? rb_dr : rb_ur) : (step[0] ? rb_dl : rb_ul);
    case (step[2:1])
      2'd0:    sel_p = p_ul;
      2'd1:    sel_p = p_ur;
      2'd2:    sel_p = p_dl;
      default: sel_p = p_dr;
    endcase
  end

  // The low DATA_WIDTH bits of a two's-complement product do not depend on
  // signedness, so a same-width multiply yields the truncated signed product.
  assign prod = mul_a * mul_b;
  assign sum  = sel_p + prod;

  // Operand capture, partial accumulation and result write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= 3'd0;
      ra_ul <= '0; ra_ur <= '0; ra_dl <= '0; ra_dr <= '0;
      rb_ul <= '0; rb_ur <= '0; rb_dl <= '0; rb_dr <= '0;
      p_ul  <= '0; p_ur  <= '0; p_dl  <= '0; p_dr  <= '0;
      c_ul  <= '0; c_ur  <= '0; c_dl  <= '0; c_dr  <= '0;
    end else if (accept) begin
      step  <= 3'd0;
      ra_ul <= a_ul; ra_ur <= a_ur; ra_dl <= a_dl; ra_dr <= a_dr;
      rb_ul <= b_ul; rb_ur <= b_ur; rb_dl <= b_dl; rb_dr <= b_dr;
      p_ul  <= accumulate ? c_ul : '0;
      p_ur  <= accumulate ? c_ur : '0;
      p_dl  <= accumulate ? c_dl : '0;
      p_dr  <= accumulate ? c_dr : '0;
    end else if (state == MUL) begin
      step <= step + 3'd1;
      case (step[2:1])
        2'd0:    p_ul <= sum;
        2'd1:    p_ur <= sum;
        2'd2:    p_dl <= sum;
        default: p_dr <= sum;
      endcase
      // Last product completes p_dr; publish the whole tile on the same edge
      if (step == 3'd7) begin
        c_ul <= p_ul;
        c_ur <= p_ur;
        c_dl <= p_dl;
        c_dr <= sum;
      end
    end
  end

endmodule
`default_nettype wire
